// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter used as a sequencer and phase generator.
// Supports direction control, enable, preset, parallel load, illegal-state detection and a wrap pulse.
module ring_counter_param #(
   parameter int unsigned W            = 4,
   parameter int unsigned SEED_IDX     = 0,
   parameter bit          AUTO_CORRECT = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         preset,
   input  logic         en,
   input  logic         dir,
   input  logic         mode,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] Q,
   output logic         wrap,
   output logic         illegal
);

   logic [W-1:0] home;
   logic [W-1:0] nxt;
   int unsigned  ones;
   int unsigned  edges;

   always_comb begin
      home = '0;
      if (!mode) home = W'(1) << SEED_IDX;
   end

   // Ring legality is a popcount of one; Johnson legality is at most one 0/1 boundary.
   always_comb begin
      ones  = 0;
      edges = 0;
      for (int unsigned i = 0; i < W; i++) begin
         ones = ones + {31'b0, Q[i]};
      end
      for (int unsigned i = 0; i + 1 < W; i++) begin
         edges = edges + {31'b0, Q[i] ^ Q[i+1]};
      end
      if (!mode) illegal = (ones != 1);
      else       illegal = (edges > 1);
   end

   always_comb begin
      if (!mode) nxt = dir ? {Q[0], Q[W-1:1]}  : {Q[W-2:0], Q[W-1]};
      else       nxt = dir ? {~Q[0], Q[W-1:1]} : {Q[W-2:0], ~Q[W-1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Q    <= '0;
         wrap <= 1'b0;
      end else if (preset) begin
         Q    <= home;
         wrap <= 1'b0;
      end else if (load) begin
         Q    <= load_val;
         wrap <= 1'b0;
      end else if (en) begin
         if (illegal && AUTO_CORRECT) begin
            Q    <= home;
            wrap <= 1'b0;
         end else begin
            Q    <= nxt;
            wrap <= (nxt == home);
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ring_counter_param.sv
// Directed-vector bench for ring_counter_param, W=4, with auto-correct on and off.
module tb_ring_counter_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0, preset = 1'b0, en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] q, q_nc;
   logic       wrap, wrap_nc, illegal, illegal_nc;
   int         checks = 0;
   int         errors = 0;

   logic [3:0] rf [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] rr [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
   logic [3:0] jf [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
   logic [3:0] jr [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

   always #5 clk = ~clk;

   ring_counter_param #(.W(4), .SEED_IDX(0), .AUTO_CORRECT(1'b1)) dut (
      .clk(clk), .reset(reset), .preset(preset), .en(en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .Q(q), .wrap(wrap), .illegal(illegal)
   );

   ring_counter_param #(.W(4), .SEED_IDX(0), .AUTO_CORRECT(1'b0)) dut_nc (
      .clk(clk), .reset(reset), .preset(preset), .en(en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .Q(q_nc), .wrap(wrap_nc), .illegal(illegal_nc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; step(); reset = 1'b0;
      checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q actual %b expected 0000", q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap actual %b expected 0", wrap); end
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL reset_illegal actual %b expected 1", illegal); end
      // Ring with Q=0: auto-correct goes home without a wrap, the other instance stays stuck at zero
      en = 1'b1; step(); en = 1'b0;
      checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("FAIL zero_correct actual q=%b wrap=%b expected q=0001 wrap=0", q, wrap); end
      checks++; if (q_nc !== 4'b0000 || wrap_nc !== 1'b0) begin errors++; $display("FAIL zero_stuck actual q=%b wrap=%b expected q=0000 wrap=0", q_nc, wrap_nc); end
   endtask

   task automatic test_ring(input logic d);
      mode = 1'b0; dir = d; preset = 1'b1; step(); preset = 1'b0;
      checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("FAIL ring_preset dir=%b actual q=%b wrap=%b expected q=0001 wrap=0", d, q, wrap); end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (q !== (d ? rr[i] : rf[i]) || wrap !== (i == 3) || illegal !== 1'b0) begin
            errors++;
            $display("FAIL ring_step dir=%b i=%0d actual q=%b wrap=%b ill=%b expected q=%b wrap=%b ill=0",
                     d, i, q, wrap, illegal, d ? rr[i] : rf[i], i == 3);
         end
      end
      en = 1'b0; dir = 1'b0;
   endtask

   task automatic test_johnson(input logic d);
      mode = 1'b1; dir = d; preset = 1'b1; step(); preset = 1'b0;
      checks++; if (q !== 4'b0000 || illegal !== 1'b0) begin errors++; $display("FAIL john_preset dir=%b actual q=%b ill=%b expected q=0000 ill=0", d, q, illegal); end
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (q !== (d ? jr[i] : jf[i]) || wrap !== (i == 7) || illegal !== 1'b0) begin
            errors++;
            $display("FAIL john_step dir=%b i=%0d actual q=%b wrap=%b ill=%b expected q=%b wrap=%b ill=0",
                     d, i, q, wrap, illegal, d ? jr[i] : jf[i], i == 7);
         end
      end
      en = 1'b0; dir = 1'b0; mode = 1'b0;
   endtask

   task automatic test_illegal();
      mode = 1'b0; dir = 1'b0; load = 1'b1; load_val = 4'b0101; step(); load = 1'b0;
      checks++; if (q !== 4'b0101 || illegal !== 1'b1) begin errors++; $display("FAIL ill_load actual q=%b ill=%b expected q=0101 ill=1", q, illegal); end
      en = 1'b1; step(); en = 1'b0;
      checks++; if (q !== 4'b0001 || illegal !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL ill_correct actual q=%b ill=%b wrap=%b expected q=0001 ill=0 wrap=0", q, illegal, wrap); end
      checks++; if (q_nc !== 4'b1010 || illegal_nc !== 1'b1 || wrap_nc !== 1'b0) begin errors++; $display("FAIL ill_nocorrect actual q=%b ill=%b wrap=%b expected q=1010 ill=1 wrap=0", q_nc, illegal_nc, wrap_nc); end
      mode = 1'b1; load = 1'b1; load_val = 4'b0101; step();
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL john_ill_0101 actual %b expected 1", illegal); end
      load_val = 4'b1111; step(); load = 1'b0;
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL john_legal_1111 actual %b expected 0", illegal); end
      mode = 1'b0;
   endtask

   task automatic test_priority();
      mode = 1'b0; reset = 1'b1; preset = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'b1000; step();
      checks++; if (q !== 4'b0000 || wrap !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL prio_reset actual q=%b wrap=%b ill=%b expected q=0000 wrap=0 ill=1", q, wrap, illegal); end
      reset = 1'b0; step();
      checks++; if (q !== 4'b0001) begin errors++; $display("FAIL prio_preset actual %b expected 0001", q); end
      preset = 1'b0; load = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("FAIL prio_hold i=%0d actual q=%b wrap=%b expected q=0001 wrap=0", i, q, wrap); end
      end
   endtask

   task automatic test_wrap_drop();
      mode = 1'b0; preset = 1'b1; step(); preset = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_before_hold actual %b expected 1", wrap); end
      en = 1'b0; step();
      checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("FAIL wrap_drop actual q=%b wrap=%b expected q=0001 wrap=0", q, wrap); end
   endtask

   task automatic test_mode_switch();
      mode = 1'b1; dir = 1'b0; preset = 1'b1; step(); preset = 1'b0; en = 1'b1;
      step(); step(); en = 1'b0;
      checks++; if (q !== 4'b0011 || illegal !== 1'b0) begin errors++; $display("FAIL msw_john actual q=%b ill=%b expected q=0011 ill=0", q, illegal); end
      mode = 1'b0; #1;
      checks++; if (illegal !== 1'b1 || q !== 4'b0011) begin errors++; $display("FAIL msw_immediate actual q=%b ill=%b expected q=0011 ill=1", q, illegal); end
      en = 1'b1; step(); en = 1'b0;
      checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("FAIL msw_correct actual q=%b wrap=%b expected q=0001 wrap=0", q, wrap); end
      checks++; if (q_nc !== 4'b0110 || illegal_nc !== 1'b1) begin errors++; $display("FAIL msw_nocorrect actual q=%b ill=%b expected q=0110 ill=1", q_nc, illegal_nc); end
   endtask

   initial begin
      step();
      test_reset();
      test_ring(1'b0);
      test_ring(1'b1);
      test_johnson(1'b0);
      test_johnson(1'b1);
      test_illegal();
      test_priority();
      test_wrap_drop();
      test_mode_switch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
